logic_unit_pipe: RTL and testbench

Parametrised, pipelined bitwise logic unit and the successor to the single-bit dataflow gate block. It applies one of eight two-operand logic functions, selected per transaction, to WIDTH-bit operands. Results are registered through a two-stage valid/ready pipeline with result flags. An accumulate mode chains results back as operand A. It sits between a command source and any consumer that needs throttled, in-order bitwise results.

---
 rtl/logic_unit_pkg.sv | 14 +
 rtl/logic_op_core.sv | 26 ++
 rtl/logic_unit_pipe.sv | 67 ++++++
 tb/tb_logic_unit_pipe.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: op encoding shared by the logic unit pipeline
package logic_unit_pkg;
    localparam int OP_W = 3;
    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NAND = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOTA = 3'd6,
        OP_NOTB = 3'd7
    } op_e;
endpackage

// File: rtl/logic_op_core.sv
// logic_op_core: combinational bitwise two-operand function selected by op
module logic_op_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    always_comb begin
        y = '0;
        case (op_e'(op))
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_NOTA: y = ~a;
            OP_NOTB: y = ~b;
            default: y = '0;
        endcase
    end
endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage valid/ready bitwise logic unit with accumulator and result flags
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic             acc_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             ones,
    output logic             parity
);
    logic             s1_valid, s1_acc, s2_valid, s2_load, in_fire;
    logic [OP_W-1:0]  s1_op;
    logic [WIDTH-1:0] s1_a, s1_b, acc_q, a_eff, res;

    assign s2_load   = s1_valid && (!s2_valid || out_ready);
    assign in_ready  = !s1_valid || s2_load;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = s2_valid;
    assign a_eff     = s1_acc ? acc_q : s1_a;

    logic_op_core #(.WIDTH(WIDTH)) u_core (
        .op(s1_op),
        .a (a_eff),
        .b (s1_b),
        .y (res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            acc_q    <= '0;
            y        <= '0;
            zero     <= 1'b1;
            ones     <= 1'b0;
            parity   <= 1'b0;
        end else begin
            s1_valid <= in_fire || (s1_valid && !s2_load);
            s2_valid <= s2_load || (s2_valid && !out_ready);
            acc_q    <= acc_clr ? '0 : s2_load ? res : acc_q;
            if (in_fire) begin
                s1_op  <= op;
                s1_acc <= acc_mode;
                s1_a   <= a;
                s1_b   <= b;
            end
            if (s2_load) begin
                y      <= res;
                zero   <= res == '0;
                ones   <= &res;
                parity <= ^res;
            end
        end
    end
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed self-checking bench for logic_unit_pipe at WIDTH 8
module tb_logic_unit_pipe;
    logic       clk = 0, rst = 1, in_valid = 0, acc_mode = 0, acc_clr = 0, out_ready = 1;
    logic [2:0] op = 0;
    logic [7:0] a = 0, b = 0;
    logic       in_ready, out_valid, zero, ones, parity;
    logic [7:0] y;
    int         checks = 0, errors = 0;
    logic [7:0] exp_ops [8] = '{8'h05, 8'hAF, 8'hFA, 8'h50, 8'hAA, 8'h55, 8'h5A, 8'hF0};

    logic_unit_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .acc_mode(acc_mode), .a(a), .b(b), .acc_clr(acc_clr), .out_valid(out_valid),
        .out_ready(out_ready), .y(y), .zero(zero), .ones(ones), .parity(parity)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        in_valid = 1;
        step();
        step();
        rst = 0;
        in_valid = 0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", y, 8'h00);
        chk("rst_zero", zero, 1);
        chk("rst_ones", ones, 0);
        chk("rst_parity", parity, 0);
        chk("rst_in_ready", in_ready, 1);

        a = 8'hA5;
        b = 8'h0F;
        for (int i = 0; i < 9; i++) begin
            in_valid = i < 8;
            op = 3'(i);
            step();
            if (i >= 1) begin
                chk($sformatf("op%0d_y", i - 1), y, exp_ops[i-1]);
                chk($sformatf("op%0d_valid", i - 1), out_valid, 1);
            end
            if (i == 5) begin
                chk("xor_parity", parity, 0);
                chk("xor_zero", zero, 0);
                chk("xor_ones", ones, 0);
            end
        end
        in_valid = 0;
        step();
        chk("ops_drain", out_valid, 0);

        out_ready = 0;
        op = 3'd4;
        a = 8'h00;
        b = 8'h01;
        in_valid = 1;
        chk("bp_ready0", in_ready, 1);
        step();
        b = 8'h02;
        chk("bp_ready1", in_ready, 1);
        step();
        b = 8'h03;
        chk("bp_full_ready", in_ready, 0);
        chk("bp_full_valid", out_valid, 1);
        chk("bp_full_y", y, 8'h01);
        step();
        chk("bp_hold_ready", in_ready, 0);
        chk("bp_hold_y", y, 8'h01);
        out_ready = 1;
        #1;
        chk("bp_rise_ready", in_ready, 1);
        step();
        in_valid = 0;
        chk("bp_y2", y, 8'h02);
        step();
        chk("bp_y3", y, 8'h03);
        chk("bp_y3_valid", out_valid, 1);
        step();
        chk("bp_drain", out_valid, 0);

        acc_clr = 1;
        step();
        acc_clr = 0;
        op = 3'd1;
        acc_mode = 1;
        a = 8'hCC;
        in_valid = 1;
        b = 8'h01;
        step();
        b = 8'h02;
        step();
        chk("acc_y1", y, 8'h01);
        b = 8'h04;
        step();
        chk("acc_y3", y, 8'h03);
        op = 3'd5;
        b = 8'h07;
        step();
        chk("acc_y7", y, 8'h07);
        in_valid = 0;
        step();
        chk("acc_xnor_y", y, 8'hFF);
        chk("acc_xnor_ones", ones, 1);

        op = 3'd1;
        b = 8'h80;
        in_valid = 1;
        step();
        in_valid = 0;
        acc_clr = 1;
        step();
        acc_clr = 0;
        chk("clr_coll_y", y, 8'hFF);
        b = 8'h01;
        in_valid = 1;
        step();
        in_valid = 0;
        step();
        chk("clr_after_y", y, 8'h01);

        out_ready = 0;
        acc_mode = 0;
        b = 8'h00;
        a = 8'h33;
        in_valid = 1;
        step();
        a = 8'h44;
        step();
        in_valid = 0;
        chk("mid_full_valid", out_valid, 1);
        rst = 1;
        step();
        rst = 0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_y", y, 8'h00);
        chk("mid_rst_ready", in_ready, 1);
        out_ready = 1;
        step();
        chk("mid_no_stale", out_valid, 0);
        acc_mode = 1;
        a = 8'h5A;
        b = 8'h00;
        in_valid = 1;
        step();
        in_valid = 0;
        step();
        chk("mid_acc_valid", out_valid, 1);
        chk("mid_acc_y", y, 8'h00);
        chk("mid_acc_zero", zero, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
